// File: rtl/detect_window_counter_pkg.sv
// -----------------------------------------------------------------------------
// detect_window_counter_pkg
// Constants shared by the windowed detection counter and its sub-blocks:
//   - window FSM state encoding (1-bit, legacy localparam style)
//   - default WINDOW_LEN, COUNT_W and THRESH values
// -----------------------------------------------------------------------------
package detect_window_counter_pkg;

    // Window FSM state encoding
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] COUNT = 1'b1;

    // Default configuration
    localparam int DEFAULT_WINDOW_LEN = 16;
    localparam int DEFAULT_COUNT_W    = 5;
    localparam int DEFAULT_THRESH     = 4;

endpackage : detect_window_counter_pkg

// File: rtl/detect_window_counter_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// COUNT_W-bit saturating accumulator with a sticky saturation flag.
// It also exposes the value the accumulator would take on this edge, so the
// owner can capture a final count that includes the current increment.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   clear      in   synchronous clear of count and flag (wins over inc)
//   inc        in   add one, saturating at 2^COUNT_W-1
//   count      out  registered accumulator value
//   sat        out  registered flag: an increment was attempted at maximum
//   next_count out  accumulator value after applying inc this cycle
//   next_sat   out  saturation flag after applying inc this cycle
// -----------------------------------------------------------------------------
module sat_counter
    import detect_window_counter_pkg::*;
#(
    parameter int COUNT_W = DEFAULT_COUNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               inc,
    output logic [COUNT_W-1:0] count,
    output logic               sat,
    output logic [COUNT_W-1:0] next_count,
    output logic               next_sat
);

    localparam logic [COUNT_W-1:0] MAX_C = {COUNT_W{1'b1}};

    logic [COUNT_W-1:0] count_r;
    logic               sat_r;
    logic               at_max_s;
    logic [COUNT_W-1:0] next_count_s;
    logic               next_sat_s;

    // Saturating increment and sticky flag update
    always_comb begin
        at_max_s     = (count_r == MAX_C);
        next_count_s = count_r;
        next_sat_s   = sat_r;
        if (inc) begin
            if (at_max_s) begin
                next_count_s = count_r;
                next_sat_s   = 1'b1;
            end else begin
                next_count_s = count_r + COUNT_W'(1);
                next_sat_s   = sat_r;
            end
        end else begin
            next_count_s = count_r;
            next_sat_s   = sat_r;
        end
    end

    // Accumulator register; clear discards the running total
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {COUNT_W{1'b0}};
            sat_r   <= 1'b0;
        end else if (clear) begin
            count_r <= {COUNT_W{1'b0}};
            sat_r   <= 1'b0;
        end else begin
            count_r <= next_count_s;
            sat_r   <= next_sat_s;
        end
    end

    assign count      = count_r;
    assign sat        = sat_r;
    assign next_count = next_count_s;
    assign next_sat   = next_sat_s;

endmodule : sat_counter

// File: rtl/detect_window_counter.sv
// -----------------------------------------------------------------------------
// detect_window_counter
// Counts detector-high cycles over back-to-back windows of WINDOW_LEN clocks,
// publishes each window's final count over a valid/ready handshake, flags
// dropped results (sticky overrun) and pulses alarm when a window's final
// count reaches THRESH.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset, highest priority
//   enable     in   run/stop; dropping it discards the partial window
//   det        in   detector output; each high cycle is one detection
//   res_ready  in   consumer accepts the held result this cycle
//   res_valid  out  result available
//   res_count  out  final count of the published window
//   res_sat    out  published window saturated
//   overrun    out  sticky: a completed window was dropped
//   alarm      out  one-cycle pulse after a window whose count >= THRESH
// -----------------------------------------------------------------------------
module detect_window_counter
    import detect_window_counter_pkg::*;
#(
    parameter int WINDOW_LEN = DEFAULT_WINDOW_LEN,
    parameter int COUNT_W    = DEFAULT_COUNT_W,
    parameter int THRESH     = DEFAULT_THRESH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               det,
    input  logic               res_ready,
    output logic               res_valid,
    output logic [COUNT_W-1:0] res_count,
    output logic               res_sat,
    output logic               overrun,
    output logic               alarm
);

    localparam int                 CYC_W    = $clog2(WINDOW_LEN);
    localparam logic [CYC_W-1:0]   LAST_CYC = CYC_W'(WINDOW_LEN - 1);
    // Threshold is compared unsigned at the count width
    localparam logic [COUNT_W-1:0] THRESH_C = COUNT_W'(THRESH);
    localparam logic               ALARM_EN = (THRESH != 0);

    logic [0:0]         state_r;
    logic [0:0]         state_nxt_s;
    logic [CYC_W-1:0]   cyc_cnt_r;
    logic               res_valid_r;
    logic [COUNT_W-1:0] res_count_r;
    logic               res_sat_r;
    logic               overrun_r;
    logic               alarm_r;

    logic               counting_s;
    logic               window_end_s;
    logic               acc_clear_s;
    logic               acc_inc_s;
    logic [COUNT_W-1:0] acc_s;
    logic               acc_sat_s;
    logic [COUNT_W-1:0] final_count_s;
    logic               final_sat_s;
    logic               load_s;
    logic               drop_s;
    logic               xfer_s;
    logic               alarm_hit_s;

    // Running detection total for the current window
    sat_counter #(
        .COUNT_W    (COUNT_W)
    ) u_acc (
        .clock      (clock),
        .reset      (reset),
        .clear      (acc_clear_s),
        .inc        (acc_inc_s),
        .count      (acc_s),
        .sat        (acc_sat_s),
        .next_count (final_count_s),
        .next_sat   (final_sat_s)
    );

    // Window qualification, accumulator control and publish decisions
    always_comb begin
        counting_s   = (state_r == COUNT) && enable;
        window_end_s = counting_s && (cyc_cnt_r == LAST_CYC);
        acc_inc_s    = counting_s && det;
        // Accumulator is held at zero outside COUNT and restarts at each
        // window end so the next window begins with no gap.
        acc_clear_s  = (!counting_s) || window_end_s;
        xfer_s       = res_valid_r && res_ready;
        load_s       = window_end_s && ((!res_valid_r) || res_ready);
        drop_s       = window_end_s && res_valid_r && (!res_ready);
        alarm_hit_s  = window_end_s && ALARM_EN && (final_count_s >= THRESH_C);
    end

    // Next-state logic of the window FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_nxt_s = COUNT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            COUNT: begin
                if (enable) begin
                    state_nxt_s = COUNT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state and cycle-in-window counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            cyc_cnt_r <= {CYC_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (!counting_s || window_end_s) begin
                cyc_cnt_r <= {CYC_W{1'b0}};
            end else begin
                cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
            end
        end
    end

    // Result register and handshake; a load wins over a simultaneous transfer
    always_ff @(posedge clock) begin
        if (reset) begin
            res_valid_r <= 1'b0;
            res_count_r <= {COUNT_W{1'b0}};
            res_sat_r   <= 1'b0;
        end else if (load_s) begin
            res_valid_r <= 1'b1;
            res_count_r <= final_count_s;
            res_sat_r   <= final_sat_s;
        end else if (xfer_s) begin
            res_valid_r <= 1'b0;
            res_count_r <= res_count_r;
            res_sat_r   <= res_sat_r;
        end else begin
            res_valid_r <= res_valid_r;
            res_count_r <= res_count_r;
            res_sat_r   <= res_sat_r;
        end
    end

    // Sticky overrun and registered alarm pulse (alarm fires even on a drop)
    always_ff @(posedge clock) begin
        if (reset) begin
            overrun_r <= 1'b0;
            alarm_r   <= 1'b0;
        end else begin
            overrun_r <= overrun_r || drop_s;
            alarm_r   <= alarm_hit_s;
        end
    end

    assign res_valid = res_valid_r;
    assign res_count = res_count_r;
    assign res_sat   = res_sat_r;
    assign overrun   = overrun_r;
    assign alarm     = alarm_r;

endmodule : detect_window_counter

// File: tb/tb_detect_window_counter.sv
// -----------------------------------------------------------------------------
// tb_detect_window_counter
// Directed bench. Instance A: WINDOW_LEN=8, COUNT_W=4, THRESH=3.
// Instance B: WINDOW_LEN=20, COUNT_W=4, THRESH=3 (saturation case).
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_detect_window_counter;

    logic       clock;
    logic       reset, enable, det, res_ready;
    logic       res_valid, res_sat, overrun, alarm;
    logic [3:0] res_count;

    logic       reset_b, enable_b, det_b, res_ready_b;
    logic       res_valid_b, res_sat_b, overrun_b, alarm_b;
    logic [3:0] res_count_b;

    int errors = 0;
    int checks = 0;

    detect_window_counter #(
        .WINDOW_LEN (8),
        .COUNT_W    (4),
        .THRESH     (3)
    ) dut_a (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .det        (det),
        .res_ready  (res_ready),
        .res_valid  (res_valid),
        .res_count  (res_count),
        .res_sat    (res_sat),
        .overrun    (overrun),
        .alarm      (alarm)
    );

    detect_window_counter #(
        .WINDOW_LEN (20),
        .COUNT_W    (4),
        .THRESH     (3)
    ) dut_b (
        .clock      (clock),
        .reset      (reset_b),
        .enable     (enable_b),
        .det        (det_b),
        .res_ready  (res_ready_b),
        .res_valid  (res_valid_b),
        .res_count  (res_count_b),
        .res_sat    (res_sat_b),
        .overrun    (overrun_b),
        .alarm      (alarm_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic v, input logic [3:0] c,
                           input logic s, input logic o, input logic a);
        check({tag, ".res_valid"}, 32'(res_valid), 32'(v));
        check({tag, ".res_count"}, 32'(res_count), 32'(c));
        check({tag, ".res_sat"},   32'(res_sat),   32'(s));
        check({tag, ".overrun"},   32'(overrun),   32'(o));
        check({tag, ".alarm"},     32'(alarm),     32'(a));
    endtask

    // Runs window cycles first..8 of instance A, det taken from pat[k-1]
    task automatic run_window(input int first, input logic [7:0] pat);
        for (int k = first; k <= 8; k++) begin
            det = pat[k-1];
            @(negedge clock);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; det = 1'b0; res_ready = 1'b0;
        reset_b = 1'b1; enable_b = 1'b0; det_b = 1'b0; res_ready_b = 1'b0;
        repeat (3) @(negedge clock);
        check_a("reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Test 1: det on cycles 1,2,6 -> count 3, alarm at threshold
        reset = 1'b0; enable = 1'b1; res_ready = 1'b1; det = 1'b1;
        @(negedge clock);                       // IDLE->COUNT, det ignored
        check_a("t1_enter", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        run_window(1, 8'b0010_0011);
        check_a("t1_result", 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
        det = 1'b0;                             // window 2 cycle 1
        @(negedge clock);
        check("t1_valid_fall", 32'(res_valid), 32'd0);
        check("t1_alarm_1cyc", 32'(alarm), 32'd0);

        // Test 2: consumer stalled for two windows (2 then 5)
        res_ready = 1'b0;
        run_window(2, 8'b0000_1100);
        check_a("t2_first", 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        run_window(1, 8'b1001_1101);
        check_a("t2_drop", 1'b1, 4'd2, 1'b0, 1'b1, 1'b1);
        res_ready = 1'b1; det = 1'b0;           // window 4 cycle 1
        @(negedge clock);
        check_a("t2_xfer", 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);

        // Test 4: enable dropped on window cycle 5, partial window discarded
        det = 1'b1;
        repeat (3) @(negedge clock);            // cycles 2..4
        enable = 1'b0;                          // cycle 5
        @(negedge clock);
        check("t4_no_valid", 32'(res_valid), 32'd0);
        enable = 1'b1;                          // IDLE->COUNT
        @(negedge clock);
        check("t4_idle_valid", 32'(res_valid), 32'd0);
        run_window(1, 8'hFF);
        check_a("t4_fresh", 1'b1, 4'd8, 1'b0, 1'b1, 1'b1);

        // Test 6: reset on window cycle 4 with a result pending
        res_ready = 1'b0;
        repeat (3) @(negedge clock);            // cycles 1..3, det=1
        check("t6_hold_valid", 32'(res_valid), 32'd1);
        check("t6_hold_count", 32'(res_count), 32'd8);
        reset = 1'b1;                           // cycle 4
        @(negedge clock);
        check_a("t6_reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0; res_ready = 1'b1;
        @(negedge clock);                       // IDLE->COUNT
        check("t6_idle_valid", 32'(res_valid), 32'd0);
        run_window(1, 8'b0000_1111);
        check_a("t6_fresh", 1'b1, 4'd4, 1'b0, 1'b0, 1'b1);

        // Test 5: window end coincides with a transfer
        res_ready = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            det = (k == 1);
            @(negedge clock);
        end
        check("t5_stable_count", 32'(res_count), 32'd4);
        check("t5_stable_valid", 32'(res_valid), 32'd1);
        res_ready = 1'b1; det = 1'b1;           // cycle 8
        @(negedge clock);
        check_a("t5_reload", 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        det = 1'b0;
        @(negedge clock);
        check("t5_valid_fall", 32'(res_valid), 32'd0);
        enable = 1'b0;

        // Test 3: WINDOW_LEN=20 with det every cycle saturates a 4-bit count
        check("t3_reset_valid", 32'(res_valid_b), 32'd0);
        reset_b = 1'b0; enable_b = 1'b1; det_b = 1'b1; res_ready_b = 1'b1;
        @(negedge clock);                       // IDLE->COUNT
        repeat (19) @(negedge clock);
        check("t3_not_yet", 32'(res_valid_b), 32'd0);
        @(negedge clock);
        check("t3_valid", 32'(res_valid_b), 32'd1);
        check("t3_count", 32'(res_count_b), 32'd15);
        check("t3_sat",   32'(res_sat_b),   32'd1);
        check("t3_alarm", 32'(alarm_b),     32'd1);
        check("t3_overrun", 32'(overrun_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_detect_window_counter

// File: doc/detect_window_counter.md
Name: detect_window_counter

Overview:
- Downstream consumer of the serial 0101/1010 pattern detector's Moore output.
- Counts detection cycles over fixed windows of WINDOW_LEN clocks.
- Publishes each window's count over a valid/ready handshake and raises a one-cycle alarm when a window reaches a threshold.
- Sits between the detector and the status/readout logic.

Parameters:
- WINDOW_LEN, 16: clocks per counting window; legal range >= 2.
- COUNT_W, 5: width of the detection count; saturates at 2^COUNT_W-1.
- THRESH, 4: alarm threshold on the final window count; 0 disables the alarm.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  run/stop; sampled every cycle.
- det  input  1  detector output; each high cycle counts as one detection.
- res_ready  input  1  consumer accepts the result this cycle.
- res_valid  output  1  result available.
- res_count  output  COUNT_W  final count of the published window.
- res_sat  output  1  published window saturated.
- overrun  output  1  sticky: a completed window was dropped.
- alarm  output  1  one-cycle pulse when a window's final count >= THRESH.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; internal cyc_cnt=0, acc=0, acc_sat=0.
  - All outputs 0: res_valid, res_count, res_sat, overrun, alarm.
  - Reset has priority over every other event, including mid-window; the partial window is discarded.
- States: IDLE, COUNT.
  - IDLE, enable=1 -> COUNT. det is ignored in IDLE. The first counted cycle is the first cycle in COUNT.
  - COUNT, enable=0 -> IDLE. That cycle's det is not counted, the partial window is discarded and nothing is published.
  - COUNT, enable=1:
    - acc += det, saturating at 2^COUNT_W-1.
    - acc_sat is set if an increment is attempted at the maximum.
    - cyc_cnt increments.
- Window end, when cyc_cnt==WINDOW_LEN-1 in COUNT with enable=1:
  - That cycle's det is included.
  - final = saturating acc+det; final_sat = acc_sat, or an increment attempted at max.
  - At that edge: cyc_cnt=0, acc=0, acc_sat=0. The next window starts the following cycle with no gap.
- Publish, on the window-end edge:
  - If res_valid=0, or res_valid=1 with res_ready=1 that cycle: res_count=final, res_sat=final_sat, res_valid=1.
  - Otherwise (res_valid=1, res_ready=0): the new result is dropped, the held result is unchanged, and overrun is set. overrun is cleared only by reset.
- Handshake:
  - Transfer occurs on an edge where res_valid=1 and res_ready=1; res_valid falls at that edge unless a new result loads simultaneously.
  - res_count and res_sat are stable while res_valid=1 and not transferred.
  - res_ready is ignored when res_valid=0.
- Alarm:
  - Registered. alarm=1 for exactly the cycle after a window end when THRESH!=0 and final>=THRESH.
  - Asserted even if that result is dropped.
  - Consecutive windows can produce an alarm every WINDOW_LEN cycles.
- Latency:
  - det on the last window cycle appears in res_count one cycle later.
  - The first result appears WINDOW_LEN+1 cycles after the IDLE->COUNT edge.
- Widths: cyc_cnt is $clog2(WINDOW_LEN) bits; THRESH is compared unsigned at COUNT_W bits.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=1'b0, COUNT=1'b1), shared with the FSM blocks' state localparam style;
  - the default WINDOW_LEN, COUNT_W and THRESH constants.
- One natural sub-module, sat_counter: a COUNT_W-bit saturating accumulator with clear, inc and sat-flag outputs.
- The window FSM, result register and handshake stay in the top module.

Test Plan:
(WINDOW_LEN=8, COUNT_W=4, THRESH=3 unless stated.)
1. Reset, then enable=1; det=1 on window cycles 1, 2 and 6, res_ready=1 -> one cycle after window end: res_valid=1, res_count=3, res_sat=0, alarm pulse exactly 1 cycle; res_valid falls on the next edge.
2. res_ready=0 across two full windows (counts 2 then 5) -> res_count holds 2, overrun=1 after the second window end, alarm pulses for the second window only; then res_ready=1 -> transfer of 2, res_valid falls.
3. WINDOW_LEN=20, det=1 every cycle -> res_count=15, res_sat=1, alarm=1.
4. enable dropped on window cycle 5 with det=1 throughout -> no res_valid; re-enable -> the next result counts from zero (res_count=8 for a full window of det=1).
5. Window end on the same edge as a res_valid&res_ready transfer -> res_valid stays 1, res_count updates to the new value, overrun stays 0.
6. reset asserted on window cycle 4 with a result pending -> the next cycle has all outputs 0, state IDLE; a subsequent enable starts a fresh window.
